// File: rtl/capture_pkg.sv
// Shared definitions for the frame capture slice: sequencer states, default
// frame geometry and a constant-multiplier helper used for address math.
package capture_pkg;

  localparam int H_RES_DEFAULT      = 320;
  localparam int V_RES_DEFAULT      = 240;
  localparam int NUM_FRAMES_DEFAULT = 8;
  localparam int SKIP_DEFAULT       = 2;

  localparam int ADDR_W = 20;
  localparam int PIX_W  = 16;
  localparam int HC_W   = 11;
  localparam int VC_W   = 10;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SKIP    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Multiply by a constant as a sum of shifted copies of x, one term per set
  // bit of k (320 becomes x<<8 + x<<6). Result is truncated to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] const_mult(input logic [ADDR_W-1:0] x,
                                                   input int k);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/capture_addr_gen.sv
// Sequence-buffer write port: turns a qualified pixel plus its frame index
// into a BRAM write, registered so the write lands one cycle after the pixel.
module capture_addr_gen
  import capture_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              req,
  input  logic [HC_W-1:0]   hcount,
  input  logic [VC_W-1:0]   vcount,
  input  logic [PIX_W-1:0]  pixel,
  input  logic [IDX_W-1:0]  frame_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int FRAME_SIZE = H_RES * V_RES;

  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_addr;

  // Linear address = frame base + row base + column, all 20-bit unsigned.
  always_comb begin
    frame_base = const_mult(ADDR_W'(frame_idx), FRAME_SIZE);
    row_base   = const_mult(ADDR_W'(vcount), H_RES);
    next_addr  = frame_base + row_base + ADDR_W'(hcount);
  end

  // Register the write; address and data hold their last value between writes.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= req;
      if (req) begin
        wr_addr <= next_addr;
        wr_data <= pixel;
      end
    end
  end

endmodule

// File: rtl/frame_capture.sv
// Capture sequencer: on request, waits for a camera frame boundary, then
// stores NUM_FRAMES frames into the sequence buffer, discarding SKIP camera
// frames between each stored frame.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for start_in
//   ST_ARM     | waiting for a frame boundary before the first frame
//   ST_CAPTURE | writing in-range pixels of frame frame_idx
//   ST_SKIP    | discarding camera frames until skip_cnt expires
//   ST_DONE    | one-cycle completion pulse, then back to idle
module frame_capture
  import capture_pkg::*;
#(
  parameter int H_RES      = H_RES_DEFAULT,
  parameter int V_RES      = V_RES_DEFAULT,
  parameter int NUM_FRAMES = NUM_FRAMES_DEFAULT,
  parameter int SKIP       = SKIP_DEFAULT
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [VC_W-1:0]   vcount_in,
  input  logic              data_valid_in,
  input  logic              frame_done_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [PIX_W-1:0]  wr_data_out,
  output logic              wr_en_out,
  output logic [IDX_W-1:0]  frame_idx_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam logic [HC_W-1:0]  H_LIM     = HC_W'(H_RES);
  localparam logic [VC_W-1:0]  V_LIM     = VC_W'(V_RES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FRAMES - 1);
  // Skip timer is a down-counter loaded with SKIP-1 and expiring at zero.
  localparam logic [3:0]       SKIP_LOAD = (SKIP > 0) ? 4'(SKIP - 1) : 4'd0;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] frame_idx;
  logic [IDX_W-1:0] frame_idx_nxt;
  logic [3:0]       skip_cnt;
  logic [3:0]       skip_cnt_nxt;
  logic             pix_in_range;
  logic             wr_req;

  // A pixel is stored only while capturing and only inside the frame window.
  always_comb begin
    pix_in_range = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    wr_req       = (state == ST_CAPTURE) && data_valid_in && pix_in_range;
  end

  // State, frame index and skip timer registers.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      frame_idx <= '0;
      skip_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      frame_idx <= frame_idx_nxt;
      skip_cnt  <= skip_cnt_nxt;
    end
  end

  // Next-state logic; frame_done_in drives every transition after arming.
  always_comb begin
    state_nxt     = state;
    frame_idx_nxt = frame_idx;
    skip_cnt_nxt  = skip_cnt;
    case (state)
      ST_IDLE: begin
        if (start_in) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (frame_done_in) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (frame_done_in) begin
          if (frame_idx == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            frame_idx_nxt = frame_idx + IDX_W'(1);
            if (SKIP > 0) begin
              state_nxt    = ST_SKIP;
              skip_cnt_nxt = SKIP_LOAD;
            end
          end
        end
      end
      ST_SKIP: begin
        if (frame_done_in) begin
          if (skip_cnt == 4'd0) state_nxt = ST_CAPTURE;
          else                  skip_cnt_nxt = skip_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt     = ST_IDLE;
        frame_idx_nxt = '0;
        skip_cnt_nxt  = '0;
      end
      default: begin
        state_nxt     = ST_IDLE;
        frame_idx_nxt = '0;
        skip_cnt_nxt  = '0;
      end
    endcase
  end

  assign busy_out      = (state != ST_IDLE);
  assign done_out      = (state == ST_DONE);
  assign frame_idx_out = frame_idx;

  // The write samples the pre-increment frame index, so a pixel arriving with
  // the frame boundary still lands in the frame it belongs to.
  capture_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_addr_gen (
    .clk_pixel (clk_pixel_in),
    .rst       (rst_in),
    .req       (wr_req),
    .hcount    (hcount_in),
    .vcount    (vcount_in),
    .pixel     (pixel_in),
    .frame_idx (frame_idx),
    .wr_en     (wr_en_out),
    .wr_addr   (wr_addr_out),
    .wr_data   (wr_data_out)
  );

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture with NUM_FRAMES=2, SKIP=1.
module tb_frame_capture;

  localparam int H  = 320;
  localparam int V  = 240;
  localparam int NF = 2;
  localparam int SK = 1;
  localparam int P  = SK + 1;
  localparam int LAST_K = (NF - 1) * P + 2;

  logic        clk_pixel = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pixel;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        data_valid;
  logic        frame_done;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [3:0]  frame_idx;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  frame_capture #(
    .H_RES      (H),
    .V_RES      (V),
    .NUM_FRAMES (NF),
    .SKIP       (SK)
  ) dut (
    .clk_pixel_in  (clk_pixel),
    .rst_in        (rst),
    .start_in      (start),
    .pixel_in      (pixel),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .data_valid_in (data_valid),
    .frame_done_in (frame_done),
    .wr_addr_out   (wr_addr),
    .wr_data_out   (wr_data),
    .wr_en_out     (wr_en),
    .frame_idx_out (frame_idx),
    .busy_out      (busy),
    .done_out      (done)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Behavioural model: m_k counts camera frame boundaries since arming.
  // Camera frame k (k>=1) is stored when (k-1) is a multiple of P, as frame
  // (k-1)/P; the sequence ends at boundary LAST_K.
  bit          m_seq;
  bit          m_done;
  int          m_k;
  bit          e_wr;
  logic [19:0] e_addr;
  logic [15:0] e_data;

  always @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      m_seq = 0; m_done = 0; m_k = 0; e_wr = 0; e_addr = '0; e_data = '0;
    end else begin
      e_wr = 0;
      if (m_seq && m_k >= 1 && ((m_k - 1) % P) == 0 && data_valid &&
          int'(hcount) < H && int'(vcount) < V) begin
        e_wr   = 1;
        e_addr = 20'(((m_k - 1) / P) * H * V + int'(vcount) * H + int'(hcount));
        e_data = pixel;
      end
      if (m_done) begin
        m_done = 0;
      end else if (!m_seq) begin
        if (start) begin m_seq = 1; m_k = 0; end
      end else if (frame_done) begin
        m_k++;
        if (m_k == LAST_K) begin m_seq = 0; m_done = 1; end
      end
    end
  end

  function automatic int exp_idx();
    if (m_done) return NF - 1;
    if (m_seq && m_k > 0) return (m_k + SK - 1) / P;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk_pixel);
      if (chk_en) begin
        if (done === 1'b1) done_cnt++;
        check("wr_en", 32'(wr_en), 32'(e_wr));
        check("busy", 32'(busy), 32'(m_seq || m_done));
        check("done", 32'(done), 32'(m_done));
        check("frame_idx", 32'(frame_idx), 32'(exp_idx()));
        if (e_wr) begin
          check("wr_addr", 32'(wr_addr), 32'(e_addr));
          check("wr_data", 32'(wr_data), 32'(e_data));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic set_pix(input logic v, input int h, input int r, input logic [15:0] d);
    data_valid = v; hcount = 11'(h); vcount = 10'(r); pixel = d;
  endtask

  task automatic stimulus();
    rst = 1; start = 0; frame_done = 0; set_pix(0, 0, 0, 16'h0);
    repeat (2) @(posedge clk_pixel);
    #1;
    chk_en = 1;
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_idx", 32'(frame_idx), 0);
    rst = 0;
    step();

    // Arm, boundary, then first pixel.
    start = 1; step(); start = 0;
    check("arm_busy", 32'(busy), 1);
    set_pix(1, 9, 9, 16'h1111);
    step();
    check("arm_no_write", 32'(wr_en), 0);
    set_pix(0, 0, 0, 16'h0);
    frame_done = 1; step(); frame_done = 0;
    set_pix(1, 5, 2, 16'hF800); step(); set_pix(0, 0, 0, 16'h0);
    check("px_wr_en", 32'(wr_en), 1);
    check("px_addr", 32'(wr_addr), 645);
    check("px_data", 32'(wr_data), 32'h0000F800);

    // Out-of-range coordinates.
    set_pix(1, 320, 10, 16'hAAAA); step();
    check("h320_drop", 32'(wr_en), 0);
    set_pix(1, 10, 240, 16'hBBBB); step();
    check("v240_drop", 32'(wr_en), 0);
    set_pix(0, 0, 0, 16'h0);

    // Start while busy is ignored; capture continues.
    start = 1; step(); start = 0;
    check("busy_start_idx", 32'(frame_idx), 0);
    set_pix(1, 7, 0, 16'h0707); step(); set_pix(0, 0, 0, 16'h0);
    check("busy_start_wr", 32'(wr_en), 1);
    check("busy_start_addr", 32'(wr_addr), 7);

    // Pixel coincident with the boundary stays in frame 0.
    set_pix(1, 1, 0, 16'h0101); frame_done = 1; step();
    set_pix(0, 0, 0, 16'h0); frame_done = 0;
    check("coinc_addr", 32'(wr_addr), 1);
    check("coinc_wr", 32'(wr_en), 1);
    check("coinc_idx", 32'(frame_idx), 1);

    // Skipped camera frame.
    set_pix(1, 3, 3, 16'h3333); step(); set_pix(0, 0, 0, 16'h0);
    check("skip_no_write", 32'(wr_en), 0);
    frame_done = 1; step(); frame_done = 0;
    set_pix(1, 0, 0, 16'h1234); step(); set_pix(0, 0, 0, 16'h0);
    check("f1_base", 32'(wr_addr), 76800);

    // Final boundary with a pixel: write issues in the done cycle.
    set_pix(1, 319, 239, 16'h5A5A); frame_done = 1; step();
    set_pix(0, 0, 0, 16'h0); frame_done = 0;
    check("last_addr", 32'(wr_addr), 153599);
    check("last_wr", 32'(wr_en), 1);
    check("done_pulse", 32'(done), 1);
    step();
    check("after_done", 32'(done), 0);
    check("after_idx", 32'(frame_idx), 0);
    check("done_once", 32'(done_cnt), 1);

    // Asynchronous reset in the middle of capture.
    start = 1; step(); start = 0;
    frame_done = 1; step(); frame_done = 0;
    set_pix(1, 2, 1, 16'hCAFE); step(); step();
    #2 rst = 1;
    #1;
    check("arst_wr_en", 32'(wr_en), 0);
    check("arst_addr", 32'(wr_addr), 0);
    check("arst_data", 32'(wr_data), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_idx", 32'(frame_idx), 0);
    set_pix(0, 0, 0, 16'h0);
    step(); step();
    rst = 0;
    step();
    check("arst_no_done", 32'(done_cnt), 1);
    start = 1; step(); start = 0;
    frame_done = 1; step(); frame_done = 0;
    set_pix(1, 0, 0, 16'hABCD); step(); set_pix(0, 0, 0, 16'h0);
    check("restart_addr", 32'(wr_addr), 0);
    check("restart_wr", 32'(wr_en), 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom_range(0, 19) == 0);
      frame_done = ($urandom_range(0, 29) == 0);
      set_pix(1'($urandom_range(0, 1)), int'($urandom_range(0, 330)),
              int'($urandom_range(0, 245)), 16'($urandom));
      rst = (c == 2000);
      step();
    end
    rst = 0; start = 0; frame_done = 0; set_pix(0, 0, 0, 16'h0);
    repeat (4) step();
    check("random_done_seen", 32'(done_cnt > 1), 1);
  endtask

  initial begin
    fork
      stimulus();
      compare_loop();
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
